// File: rtl/sap_control_unit.sv
// SAP-1.5 fetch/decode/execute sequencer: one-hot bus enables and load strobes from state + opcode.
// Optional CU_ILLEGAL_OP_HALT_EN: opcode 0xE halts and raises a sticky illegal_op instead of acting as NOP.
module sap_control_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-ADDR_WIDTH-1:0] opcode,
    input  logic [2:0]                     flags,
    output logic                           pc_enable,
    output logic                           load_pc,
    output logic                           oe_pc,
    output logic                           load_mar,
    output logic                           oe_ram,
    output logic                           load_ram,
    output logic                           load_ir,
    output logic                           oe_ir,
    output logic                           load_a,
    output logic                           oe_a,
    output logic                           load_b,
    output logic [1:0]                     alu_op,
    output logic                           oe_alu,
    output logic                           load_flags,
    output logic                           load_o,
    output logic                           halt,
    output logic                           illegal_op
);

    localparam int OP_W = DATA_WIDTH - ADDR_WIDTH;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_NOP = op_t'(4'h0);
    localparam op_t OP_LDA = op_t'(4'h1);
    localparam op_t OP_LDB = op_t'(4'h2);
    localparam op_t OP_ADD = op_t'(4'h3);
    localparam op_t OP_SUB = op_t'(4'h4);
    localparam op_t OP_AND = op_t'(4'h5);
    localparam op_t OP_OR  = op_t'(4'h6);
    localparam op_t OP_STA = op_t'(4'h7);
    localparam op_t OP_LDI = op_t'(4'h8);
    localparam op_t OP_JMP = op_t'(4'h9);
    localparam op_t OP_JC  = op_t'(4'hA);
    localparam op_t OP_JZ  = op_t'(4'hB);
    localparam op_t OP_JN  = op_t'(4'hC);
    localparam op_t OP_OUT = op_t'(4'hD);
    localparam op_t OP_ILL = op_t'(4'hE);
    localparam op_t OP_HLT = op_t'(4'hF);

    typedef enum logic [2:0] {
        S_F1   = 3'd0,
        S_F2   = 3'd1,
        S_DEC  = 3'd2,
        S_E1   = 3'd3,
        S_E2   = 3'd4,
        S_E3   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_F1;
        else       state_q <= state_d;
    end

`ifdef CU_ILLEGAL_OP_HALT_EN
    logic illegal_q, illegal_d;
    assign illegal_d = illegal_q | ((state_q == S_DEC) && (opcode == OP_ILL));

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_enable  = 1'b0;
        load_pc    = 1'b0;
        oe_pc      = 1'b0;
        load_mar   = 1'b0;
        oe_ram     = 1'b0;
        load_ram   = 1'b0;
        load_ir    = 1'b0;
        oe_ir      = 1'b0;
        load_a     = 1'b0;
        oe_a       = 1'b0;
        load_b     = 1'b0;
        alu_op     = 2'b00;
        oe_alu     = 1'b0;
        load_flags = 1'b0;
        load_o     = 1'b0;
        halt       = 1'b0;

        case (state_q)
            S_F1: begin
                oe_pc    = 1'b1;
                load_mar = 1'b1;
                state_d  = S_F2;
            end
            S_F2: begin
                oe_ram    = 1'b1;
                load_ir   = 1'b1;
                pc_enable = 1'b1;
                state_d   = S_DEC;
            end
            S_DEC: begin
                if (opcode == OP_NOP)      state_d = S_F1;
                else if (opcode == OP_HLT) state_d = S_HALT;
`ifdef CU_ILLEGAL_OP_HALT_EN
                else if (opcode == OP_ILL) state_d = S_HALT;
`else
                else if (opcode == OP_ILL) state_d = S_F1;
`endif
                else                       state_d = S_E1;
            end
            S_E1: begin
                state_d = S_F1;
                case (opcode)
                    OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STA: begin
                        oe_ir    = 1'b1;
                        load_mar = 1'b1;
                        state_d  = S_E2;
                    end
                    OP_LDI: begin
                        oe_ir  = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_JMP: begin
                        oe_ir   = 1'b1;
                        load_pc = 1'b1;
                    end
                    // Conditional jumps always present the target; only the PC load is gated.
                    OP_JC: begin
                        oe_ir   = 1'b1;
                        load_pc = flags[1];
                    end
                    OP_JZ: begin
                        oe_ir   = 1'b1;
                        load_pc = flags[0];
                    end
                    OP_JN: begin
                        oe_ir   = 1'b1;
                        load_pc = flags[2];
                    end
                    OP_OUT: begin
                        oe_a   = 1'b1;
                        load_o = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                state_d = S_F1;
                case (opcode)
                    OP_LDA: begin
                        oe_ram = 1'b1;
                        load_a = 1'b1;
                    end
                    OP_LDB: begin
                        oe_ram = 1'b1;
                        load_b = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        oe_ram  = 1'b1;
                        load_b  = 1'b1;
                        state_d = S_E3;
                    end
                    OP_STA: begin
                        oe_a     = 1'b1;
                        load_ram = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E3: begin
                alu_op     = 2'(opcode - OP_ADD);
                oe_alu     = 1'b1;
                load_a     = 1'b1;
                load_flags = 1'b1;
                state_d    = S_F1;
            end
            S_HALT: begin
                halt = 1'b1;
            end
            default: state_d = S_F1;
        endcase
    end

endmodule
